// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// One 64-bit word per line; misses write back a dirty victim, then refill over req/ack.
module dcache_mem_stage #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       writeData,
    output logic              hit,
    output logic [63:0]       readData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
);
    localparam int SETS  = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - 3 - IDX_W;

    typedef enum logic [2:0] {IDLE, WB, WB_WAIT, FILL, FILL_WAIT} stateT;

    stateT            state;
    logic [TAG_W-1:0] tagArr  [SETS];
    logic [63:0]      dataArr [SETS];
    logic [SETS-1:0]  validBits;
    logic [SETS-1:0]  dirtyBits;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] missIdx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] missTag;
    logic             access;
    logic             match;
    logic             storeHit;
    logic             wbDone;
    logic             fillDone;
    logic             unusedLowBits;

    assign idx           = address[IDX_W+2:3];
    assign tag           = address[ADDR_W-1:IDX_W+3];
    assign unusedLowBits = ^address[2:0];

    assign access   = MemRead | MemWrite;
    assign match    = validBits[idx] && (tagArr[idx] == tag);
    assign hit      = !access || (state == IDLE && match);
    // A combined read+write request behaves as a store, so it returns no data.
    assign readData = (MemRead && !MemWrite && hit) ? dataArr[idx] : 64'h0;

    assign storeHit = MemWrite && (state == IDLE) && match;
    assign wbDone   = (state == WB_WAIT) && mem_ack;
    assign fillDone = (state == FILL_WAIT) && mem_ack;

    for (genvar gi = 0; gi < SETS; gi++) begin : gSet
        logic validQ;
        logic dirtyQ;
        logic isMiss;
        logic isCur;

        assign isMiss        = (missIdx == IDX_W'(gi));
        assign isCur         = (idx == IDX_W'(gi));
        assign validBits[gi] = validQ;
        assign dirtyBits[gi] = dirtyQ;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                validQ <= 1'b0;
                dirtyQ <= 1'b0;
            end else if (fillDone && isMiss) begin
                validQ <= 1'b1;
                dirtyQ <= 1'b0;
            end else if (wbDone && isMiss) begin
                dirtyQ <= 1'b0;
            end else if (storeHit && isCur) begin
                dirtyQ <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (fillDone) begin
            tagArr[missIdx]  <= missTag;
            dataArr[missIdx] <= mem_rdata;
        end else if (storeHit) begin
            dataArr[idx] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            missIdx   <= '0;
            missTag   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !match) begin
                        missIdx <= idx;
                        missTag <= tag;
                        state   <= (validBits[idx] && dirtyBits[idx]) ? WB : FILL;
                    end
                end
                WB: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= {tagArr[missIdx], missIdx, 3'b000};
                    mem_wdata <= dataArr[missIdx];
                    state     <= WB_WAIT;
                end
                WB_WAIT: begin
                    // Drop the request so the refill is seen as a fresh transfer.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {missTag, missIdx, 3'b000};
                    state    <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
